// File: rtl/shift_rows_stream.sv
// shift_rows_stream: per-beat ShiftRows/InvShiftRows byte routing into a 2-entry valid/ready FIFO
module shift_rows_stream #(
  parameter int NB = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:32*NB-1]  in_state,
  input  logic              in_inv,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:32*NB-1]  out_state,
  output logic              out_inv,
  output logic [TAG_W-1:0]  out_tag
);
  localparam int W = 32*NB;
  if (NB < 4 || NB > 8) begin : g_bad_nb
    $error("shift_rows_stream: NB must be 4..8");
  end
  function automatic int shift_of(input int r);
    return r == 0 ? 0 : r == 1 ? 1 : r == 2 ? (NB == 8 ? 3 : 2) : (NB >= 7 ? 4 : 3);
  endfunction
  logic [0:W-1] w_fwd, w_inv, w_res;
  for (genvar k = 0; k < 4*NB; k++) begin : g_byte
    localparam int R = k % 4;
    localparam int C = k / 4;
    localparam int S = shift_of(R);
    assign w_fwd[8*k +: 8] = in_state[8*(((C + S) % NB)*4 + R) +: 8];
    assign w_inv[8*k +: 8] = in_state[8*(((C - S + NB) % NB)*4 + R) +: 8];
  end
  assign w_res = in_inv ? w_inv : w_fwd;
  logic [0:W-1]     r_st  [2];
  logic             r_inv [2];
  logic [TAG_W-1:0] r_tag [2];
  logic             r_wp, r_rp;
  logic [1:0]       r_cnt;
  logic             w_push, w_pop;
  assign in_ready  = r_cnt != 2'd2;
  assign out_valid = r_cnt != 2'd0;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign out_state = r_st[r_rp];
  assign out_inv   = r_inv[r_rp];
  assign out_tag   = r_tag[r_rp];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
      r_st[0]  <= '0;
      r_st[1]  <= '0;
      r_inv[0] <= 1'b0;
      r_inv[1] <= 1'b0;
      r_tag[0] <= '0;
      r_tag[1] <= '0;
    end else begin
      if (w_push) begin
        r_st[r_wp]  <= w_res;
        r_inv[r_wp] <= in_inv;
        r_tag[r_wp] <= in_tag;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  end
endmodule

// File: tb/tb_shift_rows_stream.sv
// tb_shift_rows_stream: directed and random checks of shift_rows_stream for NB=4, 6, 8
module tb_shift_rows_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic v4 = 0, rdy4, inv4 = 0, ov4, ordy4 = 0, oinv4;
  logic [0:127] st4 = '0, ost4;
  logic [3:0] tag4 = '0, otag4;
  logic v6 = 0, rdy6, inv6 = 0, ov6, oinv6;
  logic [0:191] st6 = '0, ost6;
  logic [3:0] otag6;
  logic v8 = 0, rdy8, inv8 = 0, ov8, oinv8;
  logic [0:255] st8 = '0, ost8;
  logic [3:0] otag8;
  logic one = 1'b1;
  shift_rows_stream #(.NB(4), .TAG_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .in_state(st4), .in_inv(inv4),
    .in_tag(tag4), .out_valid(ov4), .out_ready(ordy4), .out_state(ost4), .out_inv(oinv4), .out_tag(otag4));
  shift_rows_stream #(.NB(6), .TAG_W(4)) u6 (
    .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(rdy6), .in_state(st6), .in_inv(inv6),
    .in_tag(4'd0), .out_valid(ov6), .out_ready(one), .out_state(ost6), .out_inv(oinv6), .out_tag(otag6));
  shift_rows_stream #(.NB(8), .TAG_W(4)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .in_state(st8), .in_inv(inv8),
    .in_tag(4'd0), .out_valid(ov8), .out_ready(one), .out_state(ost8), .out_inv(oinv8), .out_tag(otag8));
  localparam logic [0:127] AES_IN = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [0:127] AES_SR = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [0:191] NB6_FWD = 192'h00050a0f_04090e13_080d1217_0c111603_10150207_1401060b;
  localparam logic [0:255] NB8_FWD =
    256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;
  localparam logic [0:255] NB8_INV =
    256'h001d1613_04011a17_08051e1b_0c09021f_100d0603_14110a07_18150e0b_1c19120f;
  int passed = 0;
  int total = 0;
  task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [0:127] ref4(input logic [0:127] s, input logic inv);
    logic [0:127] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        int sc;
        sc = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[8*(4*c+r) +: 8] = s[8*(4*sc+r) +: 8];
      end
    return o;
  endfunction
  logic [0:191] ramp6;
  logic [0:255] ramp8;
  logic [0:127] a_st, b_st, c_st;
  logic [132:0] q[$];
  initial begin
    for (int i = 0; i < 24; i++) ramp6[8*i +: 8] = 8'(i);
    for (int i = 0; i < 32; i++) ramp8[8*i +: 8] = 8'(i);
    step();
    step();
    chk("rst_valid", ov4, 0);
    chk("rst_ready", rdy4, 1);
    chk("rst_state", ost4, 0);
    chk("rst_inv", oinv4, 0);
    chk("rst_tag", otag4, 0);
    rst_n = 1'b1;
    ordy4 = 1; v4 = 1; st4 = AES_IN; inv4 = 0; tag4 = 4'd5;
    step();
    v4 = 0;
    chk("aes_fwd_valid", ov4, 1);
    chk("aes_fwd_state", ost4, AES_SR);
    chk("aes_fwd_tag", {oinv4, otag4}, {1'b0, 4'd5});
    step();
    chk("aes_fwd_pulse", ov4, 0);
    v4 = 1; st4 = AES_SR; inv4 = 1; tag4 = 4'd6;
    step();
    v4 = 0;
    chk("aes_inv_state", ost4, AES_IN);
    chk("aes_inv_tag", {ov4, oinv4, otag4}, {1'b1, 1'b1, 4'd6});
    for (int i = 0; i < 16; i++) begin
      v4 = 1; st4 = {$urandom, $urandom, $urandom, $urandom}; inv4 = 1'(i); tag4 = 4'(i);
      step();
      chk("b2b_beat", {ov4, rdy4, ost4, oinv4, otag4}, {1'b1, 1'b1, ref4(st4, inv4), inv4, tag4});
    end
    v4 = 0;
    step();
    chk("b2b_empty", ov4, 0);
    v6 = 1; st6 = ramp6; inv6 = 0; v8 = 1; st8 = ramp8; inv8 = 0;
    step();
    chk("nb6_fwd", ost6, NB6_FWD);
    chk("nb8_fwd", ost8, NB8_FWD);
    chk("nb8_valid", {ov8, rdy8, ov6}, 3'b111);
    st6 = NB6_FWD; inv6 = 1; st8 = ramp8; inv8 = 1;
    step();
    chk("nb6_roundtrip", ost6, ramp6);
    chk("nb8_inv", ost8, NB8_INV);
    v6 = 0; st8 = NB8_FWD; inv8 = 1;
    step();
    chk("nb8_roundtrip", ost8, ramp8);
    v8 = 0;
    step();
    chk("nb8_empty", ov8, 0);
    a_st = {$urandom, $urandom, $urandom, $urandom};
    b_st = {$urandom, $urandom, $urandom, $urandom};
    c_st = {$urandom, $urandom, $urandom, $urandom};
    ordy4 = 0; v4 = 1; inv4 = 0; tag4 = 4'd1; st4 = a_st;
    step();
    chk("bp_one", {rdy4, ov4, otag4}, {1'b1, 1'b1, 4'd1});
    tag4 = 4'd2; st4 = b_st;
    step();
    chk("bp_full", {rdy4, otag4}, {1'b0, 4'd1});
    chk("bp_stable_a", ost4, ref4(a_st, 0));
    tag4 = 4'd3; st4 = c_st;
    step();
    chk("bp_reject", {rdy4, ov4, otag4}, {1'b0, 1'b1, 4'd1});
    chk("bp_stable_a2", ost4, ref4(a_st, 0));
    ordy4 = 1;
    step();
    chk("full_pop_no_push", {rdy4, otag4}, {1'b1, 4'd2});
    chk("bp_head_b", ost4, ref4(b_st, 0));
    ordy4 = 0;
    step();
    chk("bp_accept3", {rdy4, otag4}, {1'b0, 4'd2});
    v4 = 0; ordy4 = 1;
    step();
    chk("bp_head_c", {ov4, ost4, otag4}, {1'b1, ref4(c_st, 0), 4'd3});
    step();
    chk("bp_drained", ov4, 0);
    ordy4 = 0; v4 = 1; tag4 = 4'd7;
    step();
    tag4 = 4'd8;
    step();
    v4 = 0;
    chk("rst_mid_full", {ov4, rdy4}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {ov4, rdy4}, 2'b01);
    chk("rst_mid_state", {ost4, oinv4, otag4}, 0);
    step();
    rst_n = 1'b1;
    v4 = 1; ordy4 = 1; st4 = a_st; inv4 = 1; tag4 = 4'd9;
    step();
    v4 = 0;
    chk("post_rst_beat", {ov4, ost4, oinv4, otag4}, {1'b1, ref4(a_st, 1), 1'b1, 4'd9});
    step();
    chk("post_rst_empty", ov4, 0);
    for (int n = 0; n < 10000; n++) begin
      v4 = 1'($urandom); ordy4 = 1'($urandom); inv4 = 1'($urandom); tag4 = 4'($urandom);
      st4 = {$urandom, $urandom, $urandom, $urandom};
      chk("rand_valid", ov4, q.size() != 0);
      if (ov4 && ordy4 && q.size() != 0) chk("rand_order", {ost4, oinv4, otag4}, q.pop_front());
      if (v4 && rdy4) q.push_back({ref4(st4, inv4), inv4, tag4});
      step();
    end
    v4 = 0; ordy4 = 1;
    for (int n = 0; n < 3; n++) begin
      if (ov4 && q.size() != 0) chk("rand_drain_order", {ost4, oinv4, otag4}, q.pop_front());
      step();
    end
    chk("rand_drain_left", q.size(), 0);
    chk("rand_drain_valid", ov4, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
